// File: rtl/move_tiros_pkg.sv
// rtl/move_tiros_pkg.sv - state codes, direction codes and axis-step helper for move_tiros_multi
package move_tiros_pkg;

  // State encoding, also exported on db_estado
  localparam logic [2:0] ST_INICIO   = 3'd0;
  localparam logic [2:0] ST_ESPERA   = 3'd1;
  localparam logic [2:0] ST_LE       = 3'd2;
  localparam logic [2:0] ST_AVALIA   = 3'd3;
  localparam logic [2:0] ST_ESCREVE  = 3'd4;
  localparam logic [2:0] ST_SINALIZA = 3'd5;

  typedef enum logic [2:0] {
    INICIO   = ST_INICIO,
    ESPERA   = ST_ESPERA,
    LE       = ST_LE,
    AVALIA   = ST_AVALIA,
    ESCREVE  = ST_ESCREVE,
    SINALIZA = ST_SINALIZA
  } estado_e;

  // Direction codes stored in the shot RAM
  localparam logic [2:0] DIR_XP    = 3'd0;
  localparam logic [2:0] DIR_XN    = 3'd1;
  localparam logic [2:0] DIR_YP    = 3'd2;
  localparam logic [2:0] DIR_YN    = 3'd3;
  localparam logic [2:0] DIR_XP_YP = 3'd4;
  localparam logic [2:0] DIR_XP_YN = 3'd5;
  localparam logic [2:0] DIR_XN_YP = 3'd6;
  localparam logic [2:0] DIR_XN_YN = 3'd7;

  // Per-axis movement sense
  localparam logic [1:0] SENT_NONE = 2'd0;
  localparam logic [1:0] SENT_INC  = 2'd1;
  localparam logic [1:0] SENT_DEC  = 2'd2;

  // Returns {sai, novo}: sai flags leaving the screen; novo is the moved
  // coordinate, or the toroidally wrapped one when sai is set. The exit test
  // is done before the add/subtract so nothing wraps in the arithmetic.
  function automatic logic [32:0] passo_eixo(input logic [31:0] coord,
                                             input logic [31:0] max_c,
                                             input logic [1:0]  sentido,
                                             input logic [31:0] passo);
    logic        sai;
    logic [31:0] novo;
    sai  = 1'b0;
    novo = coord;
    case (sentido)
      SENT_INC: begin
        sai  = coord > (max_c - passo);
        novo = sai ? (coord + passo - (max_c + 32'd1)) : (coord + passo);
      end
      SENT_DEC: begin
        sai  = coord < passo;
        novo = sai ? (coord + (max_c + 32'd1) - passo) : (coord - passo);
      end
      default: ;
    endcase
    return {sai, novo};
  endfunction

endpackage

// File: rtl/contador_indice.sv
// rtl/contador_indice.sv - slot index counter with clear, enable and terminal flag
module contador_indice #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         ultimo
);

  logic [W-1:0] idx_q, idx_d;

  // Next index: clear wins over increment
  always_comb begin
    idx_d = idx_q;
    if (clr)
      idx_d = '0;
    else if (en)
      idx_d = idx_q + W'(1);
  end

  // Index register
  always_ff @(posedge clock) begin
    if (reset)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

  assign idx    = idx_q;
  assign ultimo = (idx_q == W'(N - 1));

endmodule

// File: rtl/move_tiros_multi.sv
// rtl/move_tiros_multi.sv - multi-slot shot mover; MOVE_TIROS_WRAP_EN makes exiting shots wrap
module move_tiros_multi
  import move_tiros_pkg::*;
#(
  parameter int NUM_TIROS = 8,
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int PASSO     = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             iniciar,
  output logic [$clog2(NUM_TIROS)-1:0]     mem_addr,
  input  logic [COORD_W-1:0]               mem_rd_x,
  input  logic [COORD_W-1:0]               mem_rd_y,
  input  logic [2:0]                       mem_rd_dir,
  input  logic                             mem_rd_loaded,
  output logic                             mem_we,
  output logic [COORD_W-1:0]               mem_wr_x,
  output logic [COORD_W-1:0]               mem_wr_y,
  output logic                             mem_wr_loaded,
  output logic                             pronto,
  output logic [$clog2(NUM_TIROS+1)-1:0]   ativos,
  output logic [2:0]                       db_estado
);

  localparam int IDX_W = $clog2(NUM_TIROS);
  localparam int CNT_W = $clog2(NUM_TIROS + 1);

  estado_e            state_q, state_d;
  logic               mem_we_q, mem_we_d;
  logic               pronto_q, pronto_d;
  logic [COORD_W-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic               wr_loaded_q, wr_loaded_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, ativos_q, ativos_d;
  logic [1:0]         sent_x, sent_y;
  logic [32:0]        res_x, res_y;
  logic               sai;
  logic [IDX_W-1:0]   idx;
  logic               ultimo;
  logic               unused_bits;

  contador_indice #(.N(NUM_TIROS), .W(IDX_W)) u_indice (
    .clock  (clock),
    .reset  (reset),
    .clr    (state_q == SINALIZA),
    .en     ((state_q == ESCREVE) && !ultimo),
    .idx    (idx),
    .ultimo (ultimo)
  );

  // Decode the direction code into per-axis senses and step both axes
  always_comb begin
    sent_x = SENT_NONE;
    sent_y = SENT_NONE;
    case (mem_rd_dir)
      DIR_XP:    sent_x = SENT_INC;
      DIR_XN:    sent_x = SENT_DEC;
      DIR_YP:    sent_y = SENT_INC;
      DIR_YN:    sent_y = SENT_DEC;
      DIR_XP_YP: begin sent_x = SENT_INC; sent_y = SENT_INC; end
      DIR_XP_YN: begin sent_x = SENT_INC; sent_y = SENT_DEC; end
      DIR_XN_YP: begin sent_x = SENT_DEC; sent_y = SENT_INC; end
      DIR_XN_YN: begin sent_x = SENT_DEC; sent_y = SENT_DEC; end
      default: ;
    endcase
    res_x = passo_eixo(32'(mem_rd_x), X_MAX, sent_x, PASSO);
    res_y = passo_eixo(32'(mem_rd_y), Y_MAX, sent_y, PASSO);
    sai   = res_x[32] | res_y[32];
  end

  assign unused_bits = ^{res_x[31:COORD_W], res_y[31:COORD_W]};

  // Sweep sequencer: next state and next value of every registered output
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    pronto_d    = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_loaded_d = wr_loaded_q;
    cnt_d       = cnt_q;
    ativos_d    = ativos_q;
    case (state_q)
      INICIO: state_d = ESPERA;
      ESPERA: begin
        if (iniciar) begin
          state_d = LE;
          cnt_d   = '0;
        end
      end
      LE: state_d = AVALIA;
      AVALIA: begin
        state_d  = ESCREVE;
        mem_we_d = mem_rd_loaded;
`ifdef MOVE_TIROS_WRAP_EN
        wr_x_d      = res_x[COORD_W-1:0];
        wr_y_d      = res_y[COORD_W-1:0];
        wr_loaded_d = mem_rd_loaded;
`else
        if (sai) begin
          wr_x_d      = mem_rd_x;
          wr_y_d      = mem_rd_y;
          wr_loaded_d = 1'b0;
        end else begin
          wr_x_d      = res_x[COORD_W-1:0];
          wr_y_d      = res_y[COORD_W-1:0];
          wr_loaded_d = mem_rd_loaded;
        end
`endif
      end
      ESCREVE: begin
        if (mem_we_q && wr_loaded_q)
          cnt_d = cnt_q + CNT_W'(1);
        if (ultimo) begin
          state_d  = SINALIZA;
          pronto_d = 1'b1;
        end else begin
          state_d = LE;
        end
      end
      SINALIZA: begin
        state_d  = ESPERA;
        ativos_d = cnt_q;
      end
      default: state_d = INICIO;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INICIO;
      mem_we_q    <= 1'b0;
      pronto_q    <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_loaded_q <= 1'b0;
      cnt_q       <= '0;
      ativos_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      pronto_q    <= pronto_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_loaded_q <= wr_loaded_d;
      cnt_q       <= cnt_d;
      ativos_q    <= ativos_d;
    end
  end

  assign mem_addr      = idx;
  assign mem_we        = mem_we_q;
  assign mem_wr_x      = wr_x_q;
  assign mem_wr_y      = wr_y_q;
  assign mem_wr_loaded = wr_loaded_q;
  assign pronto        = pronto_q;
  assign ativos        = ativos_q;
  assign db_estado     = state_q;

endmodule

// File: tb/tb_move_tiros_multi.sv
// tb/tb_move_tiros_multi.sv - directed self-checking bench for move_tiros_multi
module tb_move_tiros_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [2:0] mem_addr;
  logic [9:0] mem_rd_x = '0, mem_rd_y = '0;
  logic [2:0] mem_rd_dir = '0;
  logic       mem_rd_loaded = 1'b0;
  logic       mem_we;
  logic [9:0] mem_wr_x, mem_wr_y;
  logic       mem_wr_loaded;
  logic       pronto;
  logic [3:0] ativos;
  logic [2:0] db_estado;

  logic [9:0] ram_x [8];
  logic [9:0] ram_y [8];
  logic [2:0] ram_dir [8];
  logic       ram_ld [8];

  logic       tb_we = 1'b0;
  logic [2:0] tb_addr = '0;
  logic [9:0] tb_x = '0, tb_y = '0;
  logic [2:0] tb_dir = '0;
  logic       tb_ld = 1'b0;

  int we_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  move_tiros_multi dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .mem_addr      (mem_addr),
    .mem_rd_x      (mem_rd_x),
    .mem_rd_y      (mem_rd_y),
    .mem_rd_dir    (mem_rd_dir),
    .mem_rd_loaded (mem_rd_loaded),
    .mem_we        (mem_we),
    .mem_wr_x      (mem_wr_x),
    .mem_wr_y      (mem_wr_y),
    .mem_wr_loaded (mem_wr_loaded),
    .pronto        (pronto),
    .ativos        (ativos),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous shot RAM with a bench preload port
  always @(posedge clock) begin
    mem_rd_x      <= ram_x[mem_addr];
    mem_rd_y      <= ram_y[mem_addr];
    mem_rd_dir    <= ram_dir[mem_addr];
    mem_rd_loaded <= ram_ld[mem_addr];
    if (tb_we) begin
      ram_x[tb_addr] <= tb_x; ram_y[tb_addr] <= tb_y;
      ram_dir[tb_addr] <= tb_dir; ram_ld[tb_addr] <= tb_ld;
    end else if (mem_we) begin
      ram_x[mem_addr] <= mem_wr_x; ram_y[mem_addr] <= mem_wr_y;
      ram_ld[mem_addr] <= mem_wr_loaded;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input int x, input int y, input int d, input int ld);
    @(negedge clock);
    tb_we = 1'b1; tb_addr = 3'(a); tb_x = 10'(x); tb_y = 10'(y);
    tb_dir = 3'(d); tb_ld = ld[0];
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 8; i++) poke(i, 0, 0, 0, 0);
  endtask

  // Pulses iniciar for the ESPERA sample (cycle 0); lat = cycle pronto is seen
  task automatic run_sweep(output int lat);
    lat = -1;
    @(negedge clock);
    iniciar = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock); #1;
      iniciar = 1'b0;
      if (pronto) begin lat = c; break; end
    end
  endtask

  int lat, w0, p1, p2;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", int'(db_estado), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_ativos", int'(ativos), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wr_x", int'(mem_wr_x), 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("espera", int'(db_estado), 1);

    // Mixed slots: move, right-edge exit, diagonal exit and diagonal move
    clear_ram();
    poke(0, 100, 100, 0, 1);
    poke(3, 637, 50, 0, 1);
    poke(5, 2, 2, 7, 1);
    poke(6, 10, 10, 7, 1);
    w0 = we_cnt;
    run_sweep(lat);
    chk("t1_latency", lat, 25);
    @(posedge clock); #1;
    chk("t1_pronto_pulse", int'(pronto), 0);
    chk("t1_writes", we_cnt - w0, 4);
    chk("t1_s0_x", int'(ram_x[0]), 104);
    chk("t1_s0_y", int'(ram_y[0]), 100);
    chk("t1_s0_ld", int'(ram_ld[0]), 1);
    chk("t1_s6_x", int'(ram_x[6]), 6);
    chk("t1_s6_y", int'(ram_y[6]), 6);
    chk("t1_s6_ld", int'(ram_ld[6]), 1);
`ifdef MOVE_TIROS_WRAP_EN
    chk("t1_s3_x", int'(ram_x[3]), 1);
    chk("t1_s3_ld", int'(ram_ld[3]), 1);
    chk("t1_s5_x", int'(ram_x[5]), 638);
    chk("t1_s5_y", int'(ram_y[5]), 478);
    chk("t1_s5_ld", int'(ram_ld[5]), 1);
    chk("t1_ativos", int'(ativos), 4);
`else
    chk("t1_s3_x", int'(ram_x[3]), 637);
    chk("t1_s3_ld", int'(ram_ld[3]), 0);
    chk("t1_s5_x", int'(ram_x[5]), 2);
    chk("t1_s5_y", int'(ram_y[5]), 2);
    chk("t1_s5_ld", int'(ram_ld[5]), 0);
    chk("t1_ativos", int'(ativos), 2);
`endif
    chk("t1_s3_y", int'(ram_y[3]), 50);

    // All slots unloaded: no writes, nothing active
    clear_ram();
    w0 = we_cnt;
    run_sweep(lat);
    chk("t2_latency", lat, 25);
    @(posedge clock); #1;
    chk("t2_writes", we_cnt - w0, 0);
    chk("t2_ativos", int'(ativos), 0);

    // iniciar held high: back-to-back sweeps, one pronto every 26 cycles
    poke(0, 100, 100, 0, 1);
    p1 = -1; p2 = -1;
    @(negedge clock);
    iniciar = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock); #1;
      if (pronto) begin
        if (p1 < 0) p1 = c;
        else begin p2 = c; iniciar = 1'b0; break; end
      end
    end
    iniciar = 1'b0;
    chk("t3_first_pronto", p1, 25);
    chk("t3_second_pronto", p2, 51);
    repeat (3) @(posedge clock);
    #1;
    chk("t3_idle", int'(db_estado), 1);
    chk("t3_s0_x", int'(ram_x[0]), 108);
    chk("t3_ativos", int'(ativos), 1);

    // Reset at cycle 10 of a sweep, then a fresh sweep
    @(negedge clock);
    iniciar = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      iniciar = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    chk("t4_state", int'(db_estado), 0);
    chk("t4_we", int'(mem_we), 0);
    chk("t4_pronto", int'(pronto), 0);
    chk("t4_ativos", int'(ativos), 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    run_sweep(lat);
    chk("t4_latency", lat, 25);
    @(posedge clock); #1;
    chk("t4_s0_x", int'(ram_x[0]), 116);
    chk("t4_ativos", int'(ativos), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
